// File: rtl/swapping.sv
// Flip-flop memory of 2**N words with a read port, a write port and a swap engine that
// exchanges two words. Defining SWAP_FAST_EN gives a single-edge swap with no busy port.
module swapping #(
    parameter int N    = 3,
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            swap,
    input  logic            w_en,
    input  logic [N-1:0]    A_addr,
    input  logic [N-1:0]    B_addr,
    input  logic [N-1:0]    w_addr,
    input  logic [BITS-1:0] w_data,
    input  logic [N-1:0]    r_addr,
    output logic [BITS-1:0] r_data
`ifndef SWAP_FAST_EN
    ,
    output logic            busy
`endif
);

    localparam int DEPTH = 2 ** N;

    logic [DEPTH-1:0][BITS-1:0] mem;

    assign r_data = mem[r_addr];

`ifdef SWAP_FAST_EN

    // Both words are exchanged on the same edge; a write on that edge is lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem <= '0;
        end else if (swap) begin
            mem[A_addr] <= mem[B_addr];
            mem[B_addr] <= mem[A_addr];
        end else if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

`else

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_LOAD = 2'd1,
        S_MOVE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [BITS-1:0] temp;
    logic [N-1:0]    b_lat;
    logic            do_accept, do_move, do_write;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // S_LOAD and the unused encoding fall through to IDLE with no memory update.
    always_comb begin
        state_nxt = IDLE;
        do_accept = 1'b0;
        do_move   = 1'b0;
        do_write  = 1'b0;
        case (state)
            IDLE: begin
                if (swap) begin
                    do_accept = 1'b1;
                    state_nxt = S_MOVE;
                end else if (w_en) begin
                    do_write = 1'b1;
                end
            end
            S_MOVE:  do_move = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // Only the B address is needed after acceptance; A is consumed on the accept edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem   <= '0;
            temp  <= '0;
            b_lat <= '0;
        end else begin
            if (do_accept) begin
                b_lat       <= B_addr;
                temp        <= mem[A_addr];
                mem[A_addr] <= mem[B_addr];
            end
            if (do_move)  mem[b_lat]  <= temp;
            if (do_write) mem[w_addr] <= w_data;
        end
    end

    assign busy = (state != IDLE);

`endif

endmodule

// File: tb/tb_swapping.sv
// Bench for swapping: a word-level model of the memory (pending swap applied as a whole
// exchange on completion) compared every cycle, plus directed literal checks.
module tb_swapping;

    logic       clk = 1'b0;
    logic       rstn;
    logic       swap, w_en;
    logic [2:0] A_addr, B_addr, w_addr, r_addr;
    logic [7:0] w_data, r_data;
`ifndef SWAP_FAST_EN
    logic       busy;
`endif

    int checks   = 0;
    int failures = 0;

    swapping #(.N(3), .BITS(8)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .swap   (swap),
        .w_en   (w_en),
        .A_addr (A_addr),
        .B_addr (B_addr),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_addr (r_addr),
        .r_data (r_data)
`ifndef SWAP_FAST_EN
        ,
        .busy   (busy)
`endif
    );

    always #5 clk = ~clk;

    // Model: committed words, plus an optional pending exchange pa<->pb.
    logic [7:0] m [8];
    logic       pend;
    logic [2:0] pa, pb;

    function automatic logic [7:0] model_rd(input logic [2:0] a);
        // While pending, A already holds B's old value; B still shows its old value.
        if (pend && a == pa) return m[pb];
        return m[a];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) m[i] <= 8'h00;
            pend <= 1'b0;
            pa   <= 3'd0;
            pb   <= 3'd0;
        end else if (pend) begin
            m[pa] <= m[pb];
            m[pb] <= m[pa];
            pend  <= 1'b0;
        end else if (swap) begin
`ifdef SWAP_FAST_EN
            m[A_addr] <= m[B_addr];
            m[B_addr] <= m[A_addr];
`else
            pend <= 1'b1;
            pa   <= A_addr;
            pb   <= B_addr;
`endif
        end else if (w_en) begin
            m[w_addr] <= w_data;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (r_data !== model_rd(r_addr)) begin
            failures++;
            $display("FAIL model_rdata addr=%0d got=%h exp=%h t=%0t", r_addr, r_data, model_rd(r_addr), $time);
        end
`ifndef SWAP_FAST_EN
        checks++;
        if (busy !== pend) begin
            failures++;
            $display("FAIL model_busy got=%b exp=%b t=%0t", busy, pend, $time);
        end
`endif
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
        r_addr = a;
        #1;
        chk(name, r_data, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        w_en = 1'b1; w_addr = a; w_data = d;
        tick;
        w_en = 1'b0;
    endtask

    task automatic chk_busy(input logic exp, input string name);
`ifndef SWAP_FAST_EN
        chk(name, {7'd0, busy}, {7'd0, exp});
`endif
    endtask

    // Accept a swap, then wait out the engine so the result is committed.
    task automatic do_swap(input logic [2:0] a, input logic [2:0] b);
        swap = 1'b1; A_addr = a; B_addr = b;
        tick;
        swap = 1'b0;
`ifndef SWAP_FAST_EN
        chk_busy(1'b1, "busy_after_accept");
        tick;
`endif
        chk_busy(1'b0, "busy_after_done");
    endtask

    initial begin
        rstn = 1'b0; swap = 1'b0; w_en = 1'b0;
        A_addr = '0; B_addr = '0; w_addr = '0; w_data = '0; r_addr = '0;
        #12;
        for (int i = 0; i < 8; i++) rd(i[2:0], 8'h00, "reset_sweep");
        chk_busy(1'b0, "reset_busy");
        rstn = 1'b1;
        tick;
        for (int i = 0; i < 7; i++) rd(i[2:0], 8'h00, "post_reset_sweep");

        // Basic exchange 3<->4
        wr(3'd3, 8'h5A);
        wr(3'd4, 8'hC3);
        rd(3'd3, 8'h5A, "wr3");
        rd(3'd4, 8'hC3, "wr4");
        swap = 1'b1; A_addr = 3'd3; B_addr = 3'd4;
        tick;
        swap = 1'b0;
`ifndef SWAP_FAST_EN
        chk_busy(1'b1, "busy_mid");
        rd(3'd3, 8'hC3, "mid_a");
        rd(3'd4, 8'hC3, "mid_b_old");
        tick;
`endif
        chk_busy(1'b0, "busy_done");
        rd(3'd3, 8'hC3, "swap_a");
        rd(3'd4, 8'h5A, "swap_b");

        // Swap beats a simultaneous write; writes during busy are dropped
        wr(3'd2, 8'h11);
        swap = 1'b1; A_addr = 3'd6; B_addr = 3'd7;
        w_en = 1'b1; w_addr = 3'd2; w_data = 8'hFF;
        tick;
        swap = 1'b0;
`ifndef SWAP_FAST_EN
        w_data = 8'h77;
        tick;
`endif
        w_en = 1'b0;
        rd(3'd2, 8'h11, "write_dropped");

        // Self-swap leaves everything unchanged
        wr(3'd5, 8'h3C);
        do_swap(3'd5, 3'd5);
        rd(3'd5, 8'h3C, "self_swap");
        rd(3'd2, 8'h11, "self_other2");
        rd(3'd3, 8'hC3, "self_other3");
        rd(3'd4, 8'h5A, "self_other4");

        // Address changes after acceptance are ignored
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h02);
        swap = 1'b1; A_addr = 3'd3; B_addr = 3'd4;
        tick;
        swap = 1'b0; A_addr = 3'd0; B_addr = 3'd1;
        tick;
        rd(3'd3, 8'h5A, "latched_a");
        rd(3'd4, 8'hC3, "latched_b");
        rd(3'd0, 8'h01, "untouched0");
        rd(3'd1, 8'h02, "untouched1");

        // Reset in the middle of a swap
        swap = 1'b1; A_addr = 3'd3; B_addr = 3'd4;
        tick;
        swap = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_busy(1'b0, "abort_busy");
        for (int i = 0; i < 8; i++) rd(i[2:0], 8'h00, "abort_sweep");
        #3;
        rstn = 1'b1;
        tick;
        wr(3'd1, 8'hAB);
        do_swap(3'd1, 3'd2);
        rd(3'd2, 8'hAB, "after_reset_b");
        rd(3'd1, 8'h00, "after_reset_a");

        tick;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/swapping.md
SWAPPING -- requirements
Module: swapping

Interface
REQ-001 SHALL have parameter N, default 3, address width; memory depth is 2**N words.
REQ-002 SHALL have parameter BITS, default 8, data word width.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge system clock; rstn input 1, async active-low reset.
REQ-004 swap  input  1  request to exchange the contents of A_addr and B_addr.
REQ-005 w_en  input  1  write enable for the write port.
REQ-006 A_addr  input  N  first swap address.
REQ-007 B_addr  input  N  second swap address.
REQ-008 w_addr  input  N  write address.
REQ-009 w_data  input  BITS  write data.
REQ-010 r_addr  input  N  read address.
REQ-011 r_data  output  BITS  read data, mem[r_addr].
REQ-012 busy  output  1  swap in progress; exists only when SWAP_FAST_EN is undefined.

Function
REQ-013 SHALL hold 2**N words of BITS bits in flip-flops.
REQ-014 r_data SHALL be combinational, mem[r_addr], with zero-cycle latency, so a write or swap result is visible after the updating edge.
REQ-015 Swap engine states: IDLE, S_LOAD, S_MOVE; a temp register of BITS bits holds one word.
REQ-016 IDLE with swap=1 at a rising edge: accept; latch A_addr/B_addr into internal regs; temp<=mem[A]; mem[A]<=mem[B]; go to S_MOVE.
REQ-017 S_MOVE edge: mem[B_latched]<=temp; go to IDLE; the swap is complete after 2 edges from acceptance.
REQ-018 S_LOAD is reserved and unreachable; any illegal state SHALL return to IDLE on the next edge with no memory change.
REQ-019 busy SHALL be 1 exactly while state != IDLE, i.e. one cycle after acceptance.
REQ-020 In IDLE with swap=0 and w_en=1: mem[w_addr]<=w_data on the edge.
REQ-021 Simultaneous swap=1 and w_en=1 in IDLE: swap wins; the write is dropped.
REQ-022 Writes with w_en=1 while busy=1 SHALL be dropped; swap=1 while busy SHALL be ignored (no queueing).
REQ-023 A_addr==B_addr: the swap runs normally and the word is unchanged.
REQ-024 Changes to A_addr/B_addr after acceptance SHALL not affect the swap in progress.
REQ-025 Reads SHALL never be blocked; during S_MOVE, r_data at B_latched shows the old value until the completing edge.

Reset
REQ-026 rstn=0 SHALL immediately and asynchronously clear all memory words, temp and the latched addresses to 0, and force the state to IDLE.
REQ-027 During reset r_data SHALL be 0 and busy SHALL be 0.
REQ-028 Reset mid-swap SHALL abort the swap; the memory is fully zeroed.

Configuration
REQ-029 SWAP_FAST_EN defined: the swap completes in one edge (mem[A]<=mem[B] and mem[B]<=mem[A] simultaneously), there is no busy port and no FSM, and w_en on a swap edge is dropped.
REQ-030 SWAP_FAST_EN undefined: the two-edge FSM behaviour of REQ-015..REQ-025 applies.

Verification
REQ-031 Assert rstn=0, release; sweep r_addr 0..7 -> r_data=0x00 each, busy=0.
REQ-032 Write 0x5A@3 and 0xC3@4, then swap with A=3, B=4 -> busy=1 for 1 cycle; afterwards r_data@3=0xC3 and @4=0x5A (fast mode: after 1 edge, no busy).
REQ-033 With 0x11@2: swap=1 and w_en=1 (w_addr=2, w_data=0xFF) in the same cycle -> the write is dropped; during busy, write 0x77@2 -> dropped, r_data@2=0x11.
REQ-034 Swap with A=B=5 holding 0x3C -> mem[5]=0x3C after completion, all other words unchanged.
REQ-035 Accept swap 3<->4, change A_addr/B_addr to 0/1 during busy -> only words 3 and 4 are exchanged.
REQ-036 Pull rstn low during S_MOVE -> all words read 0, busy=0 immediately; a new swap is accepted after release.
